// File: rtl/mem_burst_ctrl_pkg.sv
// Purpose: shared widths, FSM state encodings and address helper for mem_burst_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_burst_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 16;

    // FSM encodings kept as plain constants so older tools can consume them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Next burst address; the last location wraps back to 0.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_rd_buf2.sv
// Purpose: 2-entry FIFO holding read data returned by the memory.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pop only when valid; push on full is accepted only with a same-cycle pop.
module rd_buf2
    import mem_burst_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_dat_o,
    output logic              valid_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] ent_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop     = pop_i && (count_q != 2'd0);
    assign do_push    = push_i && ((count_q != 2'd2) || do_pop);
    assign head_dat_o = ent_q[rd_ptr_q];
    assign valid_o    = (count_q != 2'd0);
    assign count_o    = count_q;

    // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; reset empties the buffer and zeroes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                ent_q[wr_ptr_q] <= push_dat_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Purpose: burst controller turning addr/len commands into beats on an external 16x6 sync memory.
// Latency: write beats go straight through; first read beat appears 2 edges after command accept.
// Backpressure: wr_valid gaps stall writes; rd_ready low throttles reads via the 2-entry buffer.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] beats_left_q, beats_left_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

    logic [1:0]        buf_count;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_head;

    logic              wr_beat;
    logic              rd_issue;
    logic              rd_pop;
    logic              last_beat;
    logic [2:0]        occ;

    assign wr_beat   = (state_q == ST_WRITE) && wr_valid;
    assign rd_pop    = buf_valid && rd_ready;
    assign last_beat = (beats_left_q == '0);

    // Occupancy net of this cycle's pop: issuing only below 2 guarantees the
    // buffer still has a free slot when the data lands next cycle, yet keeps
    // one beat per cycle flowing when rd_ready stays high.
    assign occ      = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, rd_pop};
    assign rd_issue = (state_q == ST_READ) && (occ < 3'd2);

    assign cmd_ready = (state_q == ST_IDLE) && (buf_count == 2'd0) && !inflight_q;
    assign busy      = (state_q != ST_IDLE) || (buf_count != 2'd0) || inflight_q;
    assign wr_ready  = (state_q == ST_WRITE);
    assign mem_we    = wr_beat && !rst;
    assign mem_din   = (state_q == ST_WRITE) ? wr_data : '0;
    assign mem_addr  = (state_q == ST_IDLE) ? hold_addr_q : cur_addr_q;
    assign rd_valid  = buf_valid;
    assign rd_data   = buf_head;

    // Write bursts finish on their last accepted beat; read bursts finish when
    // the final buffered beat leaves and nothing is left in flight.
    assign done = !rst &&
                  ((wr_beat && last_beat) ||
                   (rd_pop && (state_q == ST_IDLE) && (buf_count == 2'd1) && !inflight_q));

    // Burst FSM: command capture, then per-beat address/count advance.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_addr_d   = cmd_addr;
                    beats_left_d = cmd_len;
                    state_d      = cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_beat) begin
                    cur_addr_d   = addr_inc(cur_addr_q);
                    beats_left_d = beats_left_q - ADDR_W'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    cur_addr_d   = addr_inc(cur_addr_q);
                    beats_left_d = beats_left_q - ADDR_W'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d  = rd_issue;
        hold_addr_d = mem_addr;
    end

    // State registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
            hold_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
            hold_addr_q  <= hold_addr_d;
        end
    end

    // Read data lands from memory exactly one cycle after each issue.
    rd_buf2 u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_dat_i (mem_dout),
        .pop_i      (rd_pop),
        .head_dat_o (buf_head),
        .valid_o    (buf_valid),
        .count_o    (buf_count)
    );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Purpose: directed, table-driven bench for mem_burst_ctrl with a behavioural 16x6 sync memory.
// Latency: outputs sampled 1 time unit after each negedge, inputs driven at the negedge.
// Backpressure: rd_ready and wr_valid patterns are driven from the vectors and sequences.
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [5:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [5:0] rd_data;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [5:0] mem_din, mem_dout;
    logic       busy, done;

    logic [5:0] mem [16];
    logic [5:0] exp_mem [16];
    logic       init_mem;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done)
    );

    // External synchronous memory: write-first is irrelevant, read data registered.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 6'(i + 32);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic       cv, cw;
        logic [3:0] ca, cl;
        logic       wv;
        logic [5:0] wd;
        logic       rr;
        logic       e_cr, e_wr, e_we;
        logic [3:0] e_addr;
        logic [5:0] e_din;
        logic       e_rv;
        logic [5:0] e_rd;
        logic       e_busy, e_done;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input int cv, input int cw, input int ca, input int cl,
                                input int wv, input int wd, input int rr,
                                input int e_cr, input int e_wr, input int e_we,
                                input int e_addr, input int e_din, input int e_rv,
                                input int e_rd, input int e_busy, input int e_done);
        vec_t v;
        v.cv = 1'(cv);   v.cw = 1'(cw);   v.ca = 4'(ca);   v.cl = 4'(cl);
        v.wv = 1'(wv);   v.wd = 6'(wd);   v.rr = 1'(rr);
        v.e_cr = 1'(e_cr); v.e_wr = 1'(e_wr); v.e_we = 1'(e_we);
        v.e_addr = 4'(e_addr); v.e_din = 6'(e_din); v.e_rv = 1'(e_rv);
        v.e_rd = 6'(e_rd); v.e_busy = 1'(e_busy); v.e_done = 1'(e_done);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [21:0] act, exp;
        int          n, done_cnt, max_occ, we_seen, done_ok;

        rst = 1'b1; init_mem = 1'b1;
        cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 6'(i + 32);
        repeat (3) @(negedge clk);
        rst = 1'b0; init_mem = 1'b0;

        // One row per cycle. Columns: cv cw ca cl wv wd rr | cr wr we addr din rv rd busy done
        // Write addr=3 len=3, then addr=14 len=3 with 2-cycle wr_valid gaps, then read addr=3 len=3.
        tbl[0]  = mk(0,0, 0,0, 0,   0,0, 1,0,0, 0,   0, 0,   0, 0,0);
        tbl[1]  = mk(1,1, 3,3, 0,   0,0, 1,0,0, 0,   0, 0,   0, 0,0);
        tbl[2]  = mk(0,0, 0,0, 1,'h01,0, 0,1,1, 3,'h01, 0,   0, 1,0);
        tbl[3]  = mk(0,0, 0,0, 1,'h02,0, 0,1,1, 4,'h02, 0,   0, 1,0);
        tbl[4]  = mk(0,0, 0,0, 1,'h03,0, 0,1,1, 5,'h03, 0,   0, 1,0);
        tbl[5]  = mk(0,0, 0,0, 1,'h04,0, 0,1,1, 6,'h04, 0,   0, 1,1);
        tbl[6]  = mk(1,1,14,3, 0,   0,0, 1,0,0, 6,   0, 0,   0, 0,0);
        tbl[7]  = mk(0,0, 0,0, 1,'h0A,0, 0,1,1,14,'h0A, 0,   0, 1,0);
        tbl[8]  = mk(0,0, 0,0, 0,'h3F,0, 0,1,0,15,'h3F, 0,   0, 1,0);
        tbl[9]  = mk(0,0, 0,0, 0,'h3F,0, 0,1,0,15,'h3F, 0,   0, 1,0);
        tbl[10] = mk(0,0, 0,0, 1,'h0B,0, 0,1,1,15,'h0B, 0,   0, 1,0);
        tbl[11] = mk(0,0, 0,0, 1,'h0C,0, 0,1,1, 0,'h0C, 0,   0, 1,0);
        tbl[12] = mk(0,0, 0,0, 0,'h3F,0, 0,1,0, 1,'h3F, 0,   0, 1,0);
        tbl[13] = mk(0,0, 0,0, 0,'h3F,0, 0,1,0, 1,'h3F, 0,   0, 1,0);
        tbl[14] = mk(0,0, 0,0, 1,'h0D,0, 0,1,1, 1,'h0D, 0,   0, 1,1);
        tbl[15] = mk(1,0, 3,3, 0,   0,1, 1,0,0, 1,   0, 0,   0, 0,0);
        tbl[16] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 3,   0, 0,   0, 1,0);
        tbl[17] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 4,   0, 0,   0, 1,0);
        tbl[18] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 5,   0, 1,'h01, 1,0);
        tbl[19] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 6,   0, 1,'h02, 1,0);
        tbl[20] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 6,   0, 1,'h03, 1,0);
        tbl[21] = mk(0,0, 0,0, 0,   0,1, 0,0,0, 6,   0, 1,'h04, 1,1);
        tbl[22] = mk(0,0, 0,0, 0,   0,1, 1,0,0, 6,   0, 0,   0, 0,0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            cmd_valid = tbl[i].cv; cmd_wr = tbl[i].cw; cmd_addr = tbl[i].ca; cmd_len = tbl[i].cl;
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr;
            #1;
            // rd_data is only meaningful while valid, except right after reset where it must be 0.
            act = {cmd_ready, wr_ready, mem_we, mem_addr, mem_din, rd_valid,
                   (tbl[i].e_rv || i == 0) ? rd_data : 6'h00, busy, done};
            exp = {tbl[i].e_cr, tbl[i].e_wr, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_din,
                   tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_done};
            check($sformatf("vec%0d", i), 32'(act), 32'(exp));
        end

        exp_mem[3] = 6'h01; exp_mem[4] = 6'h02; exp_mem[5] = 6'h03; exp_mem[6] = 6'h04;
        exp_mem[14] = 6'h0A; exp_mem[15] = 6'h0B; exp_mem[0] = 6'h0C; exp_mem[1] = 6'h0D;
        check("mem3",  32'(mem[3]),  32'h01);
        check("mem4",  32'(mem[4]),  32'h02);
        check("mem5",  32'(mem[5]),  32'h03);
        check("mem6",  32'(mem[6]),  32'h04);
        check("mem14", 32'(mem[14]), 32'h0A);
        check("mem15", 32'(mem[15]), 32'h0B);
        check("mem0",  32'(mem[0]),  32'h0C);
        check("mem1",  32'(mem[1]),  32'h0D);
        check("mem2_untouched", 32'(mem[2]), 32'h22);

        // 16-beat read from addr 5 with rd_ready cycling 1,0,0,1.
        @(negedge clk);
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd5; cmd_len = 4'd15; rd_ready = 0;
        #1 check("rd16_cmd_ready", 32'(cmd_ready), 32'd1);
        n = 0; done_cnt = 0; max_occ = 0; we_seen = 0; done_ok = 0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            @(negedge clk);
            cmd_valid = 0;
            rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (int'(dut.u_rd_buf.count_o) > max_occ) max_occ = int'(dut.u_rd_buf.count_o);
            if (mem_we) we_seen = 1;
            if (done) begin
                done_cnt++;
                if (rd_valid && rd_ready && n == 15) done_ok = 1;
            end
            if (rd_valid && rd_ready) begin
                check($sformatf("rd16_beat%0d", n), 32'(rd_data), 32'(exp_mem[4'(5 + n)]));
                n++;
            end
        end
        check("rd16_beats", 32'(n), 32'd16);
        check("rd16_done_count", 32'(done_cnt), 32'd1);
        check("rd16_done_on_last_pop", 32'(done_ok), 32'd1);
        check("rd16_occ_le_2", 32'(max_occ <= 2), 32'd1);
        check("rd16_no_write", 32'(we_seen), 32'd0);
        @(negedge clk);
        rd_ready = 0;
        #1;
        check("rd16_idle_busy", 32'(busy), 32'd0);
        check("rd16_idle_ready", 32'(cmd_ready), 32'd1);
        check("rd16_no_extra_done", 32'(done), 32'd0);

        // Reset during a read with one beat buffered.
        @(negedge clk);
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd3; cmd_len = 4'd3; rd_ready = 0;
        #1 check("rstrd_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstrd_buffered_valid", 32'(rd_valid), 32'd1);
        check("rstrd_buffered_data", 32'(rd_data), 32'h01);
        rst = 1;
        #1 check("rstrd_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 0;
        #1;
        check("rstrd_rd_valid", 32'(rd_valid), 32'd0);
        check("rstrd_busy", 32'(busy), 32'd0);
        check("rstrd_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstrd_done", 32'(done), 32'd0);

        // Reset during a write: the beat offered in the reset cycle must not land.
        @(negedge clk);
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'd9; cmd_len = 4'd3;
        #1 check("rstwr_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 0; wr_valid = 1; wr_data = 6'h15;
        #1;
        check("rstwr_beat_we", 32'(mem_we), 32'd1);
        check("rstwr_beat_addr", 32'(mem_addr), 32'd9);
        @(negedge clk);
        wr_data = 6'h3C; rst = 1;
        #1;
        check("rstwr_we_in_reset", 32'(mem_we), 32'd0);
        check("rstwr_done_in_reset", 32'(done), 32'd0);
        @(negedge clk);
        rst = 0; wr_valid = 0;
        #1;
        check("rstwr_busy", 32'(busy), 32'd0);
        check("rstwr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstwr_mem_addr", 32'(mem_addr), 32'd0);
        check("rstwr_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("rstwr_mem9", 32'(mem[9]), 32'h15);
        check("rstwr_mem10", 32'(mem[10]), 32'h2A);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
